systolic_mac_pe_os: RTL and testbench

Parametrised output-stationary multiply-accumulate processing element for the next-generation systolic array. It supersedes the fixed 8-bit multiply-plus-partial-sum PE. Each PE accumulates a whole tile of products locally, applies signed or unsigned arithmetic with optional saturation, and drains finished results along a per-row result chain. Operand and control sidebands ripple east/south with one register stage per PE.

---
 rtl/systolic_mac_pe_os.sv | 198 +++++++++++++++++++
 tb/tb_systolic_mac_pe_os.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe_os.sv
// Output-stationary MAC PE: S1 operand/sideband regs, S2 product, S3 accumulate + tile FSM,
// then a one-entry hold feeding the row drain chain where upstream results take priority.
module systolic_mac_pe_os #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              vld_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              vld_out,
  output logic              first_out,
  output logic              last_out,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_vld_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_vld_out,
  output logic              sat_flag,
  output logic              proto_err,
  output logic              drop_err
);
  localparam int PW = 2 * DATA_W;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  if (ACC_W < PW + 1) begin : g_bad_acc_w
    $error("systolic_mac_pe_os: ACC_W must be at least 2*DATA_W+1");
  end

  logic [DATA_W-1:0] a_q, b_q;
  logic              vld_q, first_q, last_q;
  logic [ACC_W-1:0]  prod_q;
  logic              vld2_q, first2_q, last2_q;
  logic [0:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d, proto_q, proto_d, drop_q, drop_d;
  logic [ACC_W-1:0]  hold_q, hold_d, res_q, res_d;
  logic              hold_vld_q, hold_vld_d, res_vld_q, res_vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_in;
      b_q     <= b_in;
      vld_q   <= vld_in;
      first_q <= first_in;
      last_q  <= last_in;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign vld_out   = vld_q;
  assign first_out = first_q;
  assign last_out  = last_q;

  logic [PW-1:0]    a_ext, b_ext, prod_w;
  logic [ACC_W-1:0] prod_ext;
  assign a_ext    = SIGNED ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
  assign b_ext    = SIGNED ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
  // The low PW bits of the extended product are exact for both signed and unsigned operands.
  assign prod_w   = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-PW){SIGNED & prod_w[PW-1]}}, prod_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      vld2_q   <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else begin
      prod_q   <= prod_ext;
      vld2_q   <= vld_q;
      first2_q <= first_q;
      last2_q  <= last_q;
    end
  end

  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sum, acc_add, acc_max, acc_min, emit_val;
  logic             ovf_pos, ovf_neg, emit, drain, hold_free;

  assign sum_w   = {1'b0, acc_q} + {1'b0, prod_q};
  assign sum     = sum_w[ACC_W-1:0];
  assign acc_max = SIGNED ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  assign acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  always_comb begin
    ovf_pos = 1'b0;
    ovf_neg = 1'b0;
    if (SAT) begin
      if (SIGNED) begin
        ovf_pos = ~acc_q[ACC_W-1] & ~prod_q[ACC_W-1] &  sum[ACC_W-1];
        ovf_neg =  acc_q[ACC_W-1] &  prod_q[ACC_W-1] & ~sum[ACC_W-1];
      end else begin
        ovf_pos = sum_w[ACC_W];
      end
    end
  end

  assign acc_add = ovf_pos ? acc_max : (ovf_neg ? acc_min : sum);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    proto_d  = 1'b0;
    emit     = 1'b0;
    emit_val = acc_add;
    if (vld2_q) begin
      if (first2_q) begin
        // A first beat always opens a fresh tile, abandoning any partial sum.
        acc_d    = prod_q;
        emit_val = prod_q;
        sat_d    = 1'b0;
        proto_d  = (state_q == S_ACC);
        emit     = last2_q;
        state_d  = last2_q ? S_IDLE : S_ACC;
      end else if (state_q == S_IDLE) begin
        proto_d = 1'b1;
      end else begin
        acc_d   = acc_add;
        sat_d   = sat_q | ovf_pos | ovf_neg;
        emit    = last2_q;
        state_d = last2_q ? S_IDLE : S_ACC;
      end
    end
  end

  assign drain     = ~res_vld_in & hold_vld_q;
  assign hold_free = ~hold_vld_q | drain;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q & ~drain;
    drop_d     = 1'b0;
    if (emit) begin
      if (hold_free) begin
        hold_d     = emit_val;
        hold_vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
    res_d     = res_q;
    res_vld_d = 1'b0;
    if (res_vld_in) begin
      res_d     = res_in;
      res_vld_d = 1'b1;
    end else if (hold_vld_q) begin
      res_d     = hold_q;
      res_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      proto_q    <= 1'b0;
      drop_q     <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      res_q      <= '0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      proto_q    <= proto_d;
      drop_q     <= drop_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      res_q      <= res_d;
      res_vld_q  <= res_vld_d;
    end
  end

  assign res_out     = res_q;
  assign res_vld_out = res_vld_q;
  assign sat_flag    = sat_q;
  assign proto_err   = proto_q;
  assign drop_err    = drop_q;

endmodule

// File: tb/tb_systolic_mac_pe_os.sv
// Four PE configurations driven by shared stimulus, each checked against a tile-level reference model.
module tb_systolic_mac_pe_os;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;
  logic        vld_in = 1'b0, first_in = 1'b0, last_in = 1'b0;
  logic [31:0] res_in = '0;
  logic        res_vld_in = 1'b0;

  logic [3:0][31:0] res_out_a;
  logic [3:0][7:0]  a_out_a, b_out_a;
  logic [3:0]       vld_out_a, first_out_a, last_out_a, res_vld_a, sat_a, proto_a, drop_a;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 0: unsigned wrap 32, 1: signed wrap 32, 2: signed saturate 17, 3: unsigned saturate 17
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int AW = (g >= 2) ? 17 : 32;
    localparam bit SG = (g == 1 || g == 2);
    localparam bit ST = (g >= 2);
    logic [AW-1:0] ro;
    systolic_mac_pe_os #(.DATA_W(8), .ACC_W(AW), .SIGNED(SG), .SAT(ST)) u_dut (
      .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .vld_in(vld_in),
      .first_in(first_in), .last_in(last_in), .a_out(a_out_a[g]), .b_out(b_out_a[g]),
      .vld_out(vld_out_a[g]), .first_out(first_out_a[g]), .last_out(last_out_a[g]),
      .res_in(res_in[AW-1:0]), .res_vld_in(res_vld_in), .res_out(ro),
      .res_vld_out(res_vld_a[g]), .sat_flag(sat_a[g]), .proto_err(proto_a[g]),
      .drop_err(drop_a[g]));
    assign res_out_a[g] = 32'(ro);
  end

  function automatic int cw(input int k); return (k >= 2) ? 17 : 32; endfunction
  function automatic bit csg(input int k); return (k == 1 || k == 2); endfunction
  function automatic bit cst(input int k); return (k >= 2); endfunction

  function automatic logic [31:0] pat(input int k, input longint v);
    longint m = (64'sd1 <<< cw(k)) - 64'sd1;
    return 32'(v & m);
  endfunction

  // Bring a mathematical sum back into the accumulator's range: clamp or wrap.
  function automatic longint norm(input int k, input longint v, output bit ovf);
    longint w  = 64'sd1 <<< cw(k);
    longint hi = csg(k) ? (w / 2 - 1) : (w - 1);
    longint lo = csg(k) ? -(w / 2) : 64'sd0;
    longint r;
    ovf = 1'b0;
    if (v >= lo && v <= hi) return v;
    if (cst(k)) begin
      ovf = 1'b1;
      return (v > hi) ? hi : lo;
    end
    r = v & (w - 1);
    if (r > hi) r = r - w;
    return r;
  endfunction

  typedef struct {
    bit     emit;
    longint val;
    bit     proto;
    bit     clr;
    bit     sat_hit;
  } dec_t;

  dec_t        dl [4][2];
  bit          m_intile [4];
  longint      m_acc [4];
  bit          m_hold_v [4];
  logic [31:0] m_hold [4];
  logic [31:0] m_res [4];
  bit          m_res_v [4], m_sat [4], m_proto [4], m_drop [4];
  logic [18:0] m_sb;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_intile[k] = 1'b0; m_acc[k] = 0; m_hold_v[k] = 1'b0; m_hold[k] = '0;
      m_res[k] = '0; m_res_v[k] = 1'b0; m_sat[k] = 1'b0; m_proto[k] = 1'b0; m_drop[k] = 1'b0;
      dl[k][0] = '{default: 0};
      dl[k][1] = '{default: 0};
    end
    m_sb = '0;
  endtask

  // Tile-level decision for the beat on the inputs; takes effect two edges later.
  task automatic decide(input int k, output dec_t d);
    longint p, v;
    bit ovf;
    d = '{default: 0};
    if (!vld_in) return;
    p = csg(k) ? longint'($signed(a_in)) * longint'($signed(b_in))
               : longint'(a_in) * longint'(b_in);
    if (first_in) begin
      d.proto = m_intile[k];
      d.clr = 1'b1;
      m_acc[k] = p;
      d.emit = last_in;
      d.val = p;
      m_intile[k] = !last_in;
    end else if (!m_intile[k]) begin
      d.proto = 1'b1;
    end else begin
      v = norm(k, m_acc[k] + p, ovf);
      m_acc[k] = v;
      d.sat_hit = ovf;
      d.emit = last_in;
      d.val = v;
      m_intile[k] = !last_in;
    end
  endtask

  task automatic model_step();
    dec_t d, nd;
    bit drain;
    for (int k = 0; k < 4; k++) begin
      d = dl[k][1];
      m_proto[k] = d.proto;
      m_drop[k] = 1'b0;
      if (d.clr) m_sat[k] = d.sat_hit;
      else if (d.sat_hit) m_sat[k] = 1'b1;
      drain = !res_vld_in && m_hold_v[k];
      if (res_vld_in) begin
        m_res[k] = pat(k, longint'(res_in)); m_res_v[k] = 1'b1;
      end else if (m_hold_v[k]) begin
        m_res[k] = m_hold[k]; m_res_v[k] = 1'b1;
      end else begin
        m_res_v[k] = 1'b0;
      end
      if (drain) m_hold_v[k] = 1'b0;
      if (d.emit) begin
        if (m_hold_v[k]) m_drop[k] = 1'b1;
        else begin
          m_hold[k] = pat(k, d.val); m_hold_v[k] = 1'b1;
        end
      end
      dl[k][1] = dl[k][0];
      decide(k, nd);
      dl[k][0] = nd;
    end
    m_sb = {a_in, b_in, vld_in, first_in, last_in};
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("res_out[%0d]", k), res_out_a[k], m_res[k]);
      chk_eq($sformatf("flags[%0d]", k), 32'({res_vld_a[k], sat_a[k], proto_a[k], drop_a[k]}),
             32'({m_res_v[k], m_sat[k], m_proto[k], m_drop[k]}));
      chk_eq($sformatf("sideband[%0d]", k),
             32'({a_out_a[k], b_out_a[k], vld_out_a[k], first_out_a[k], last_out_a[k]}), 32'(m_sb));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [7:0] a, b, input logic v, f, l);
    a_in = a; b_in = b; vld_in = v; first_in = f; last_in = l;
  endtask

  task automatic wait_res(input int k, input logic [31:0] exp, input string tag);
    int n = 0;
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    do begin
      cycle();
      n++;
    end while (!res_vld_a[k] && n < 10);
    chk_eq({tag, "_vld"}, 32'(res_vld_a[k]), 32'd1);
    chk_eq(tag, res_out_a[k], exp);
  endtask

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h7F;
      default: return 8'($urandom());
    endcase
  endfunction

  initial begin
    bit seen;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    chk_eq("reset_res", res_out_a[0], 32'd0);
    rst_n = 1'b1;

    // Unsigned three-beat tile with latency and sideband echo
    drive(8'd3, 8'd4, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd5, 8'd6, 1'b1, 1'b0, 1'b0); cycle();
    drive(8'd255, 8'd255, 1'b1, 1'b0, 1'b1); cycle();
    chk_eq("t1_sideband", 32'({a_out_a[0], b_out_a[0], vld_out_a[0], first_out_a[0], last_out_a[0]}),
           32'({8'd255, 8'd255, 3'b101}));
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cycle(); cycle();
    chk_eq("t1_early", 32'(res_vld_a[0]), 32'd0);
    cycle();
    chk_eq("t1_vld", 32'(res_vld_a[0]), 32'd1);
    chk_eq("t1_sum", res_out_a[0], 32'(3 * 4 + 5 * 6 + 255 * 255));

    // Signed single-beat tile followed back-to-back by a two-beat tile
    drive(8'h80, 8'h7F, 1'b1, 1'b1, 1'b1); cycle();
    drive(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1); cycle();
    wait_res(1, 32'hFFFF_C080, "t2_single");
    wait_res(1, 32'd2, "t2_pair");

    // Signed saturation at 17 bits, then clearing on the next first beat
    drive(8'h80, 8'h80, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'h80, 8'h80, 1'b1, 1'b0, 1'b0); cycle(); cycle();
    drive(8'h80, 8'h80, 1'b1, 1'b0, 1'b1); cycle();
    wait_res(2, 32'h0_FFFF, "t3_clamp");
    chk_eq("t3_sat_set", 32'(sat_a[2]), 32'd1);
    drive(8'd1, 8'd1, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0); cycle();
    chk_eq("t3_sat_hold", 32'(sat_a[2]), 32'd1);
    cycle();
    chk_eq("t3_sat_clr", 32'(sat_a[2]), 32'd0);
    drive(8'd1, 8'd1, 1'b1, 1'b0, 1'b1); cycle();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0); repeat (4) cycle();

    // Drain conflict: upstream stream stalls the hold, second local result is dropped
    seen = 1'b0;
    res_vld_in = 1'b1; res_in = 32'd9;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(8'd7, 8'd1, 1'b1, 1'b1, 1'b1);
      else if (i == 1) drive(8'd2, 8'd3, 1'b1, 1'b1, 1'b1);
      else drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      seen |= drop_a[0];
    end
    chk_eq("t4_drop", 32'(seen), 32'd1);
    chk_eq("t4_upstream", res_out_a[0], 32'd9);
    res_vld_in = 1'b0;
    cycle();
    chk_eq("t4_kept", res_out_a[0], 32'd7);
    repeat (2) cycle();

    // Protocol: stray beat in IDLE, then a restart inside a tile
    drive(8'd5, 8'd5, 1'b1, 1'b0, 1'b0); cycle();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0); cycle();
    chk_eq("t5_proto_early", 32'(proto_a[0]), 32'd0);
    cycle();
    chk_eq("t5_proto", 32'(proto_a[0]), 32'd1);
    cycle();
    chk_eq("t5_proto_pulse", 32'(proto_a[0]), 32'd0);
    chk_eq("t5_no_res", 32'(res_vld_a[0]), 32'd0);
    drive(8'd2, 8'd2, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd3, 8'd3, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd4, 8'd4, 1'b1, 1'b0, 1'b1); cycle();
    wait_res(0, 32'd25, "t5_restart");

    // Reset in the middle of a tile, then a clean tile
    drive(8'd10, 8'd10, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd10, 8'd10, 1'b1, 1'b0, 1'b0); cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    drive(8'd0, 8'd0, 1'b0, 1'b0, 1'b0); cycle();
    rst_n = 1'b1;
    drive(8'd1, 8'd2, 1'b1, 1'b1, 1'b0); cycle();
    drive(8'd3, 8'd4, 1'b1, 1'b0, 1'b1); cycle();
    wait_res(0, 32'd14, "t6_after_reset");

    // Randomised traffic with tile protocol errors, stalls and one asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_n = 1'b1;
      end
      drive(rnd_op(), rnd_op(), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
      res_vld_in = 1'($urandom_range(0, 3) == 0);
      res_in = $urandom();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
